spi_slave_rx_fifo: RTL and testbench

Parametrised receive-only SPI slave, successor to the single-byte spiSlave. Synchronises SCK/CS/MOSI into the clk domain and supports all four SPI modes, configurable word width and bit order, and multi-word frames per CS assertion. Received words are buffered in a show-ahead FIFO with a valid/ready output handshake, word-in-frame index, and overrun/partial-frame status. Sits between the pad-level SPI pins and the RGBW register/command decoder.

---
 rtl/spi_slave_rx_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_spi_slave_rx_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_fifo.sv
// Receive-only SPI slave with a show-ahead output FIFO.
// SCK/CS/MOSI are synchronised into clk. Sample edges are detected for any
// CPOL/CPHA combination. Words are assembled MSB- or LSB-first and handed to
// a small FIFO whose head word, index and valid flag are all registered.
module spi_slave_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       cs,
  input  logic                       mosi,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       frame_end,
  output logic                       frame_partial,
  output logic                       overrun,
  input  logic                       ovr_clr,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int   AW       = $clog2(DEPTH);
  localparam int   LVL_W    = $clog2(DEPTH+1);
  localparam int   CNT_W    = $clog2(DATA_W+1);
  localparam int   ENT_W    = DATA_W + IDX_W;
  localparam logic IDLE_SCK = (CPOL != 0);

  // Synchroniser chains and front-end state
  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] settle_reg;
  logic                   sck_prev_reg;
  logic                   armed_reg;
  logic                   frame_active_reg;
  logic                   sample_reg;
  logic                   mosi_d_reg;
  logic                   cs_rise_reg;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic leading_edge;
  logic trailing_edge;
  logic sample_edge;
  logic cs_rise;

  // Word assembly state
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_in;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CNT_W-1:0]  cnt_base;
  logic [IDX_W-1:0]  idx_reg;
  logic              word_done;
  logic              push_req_reg;
  logic [DATA_W-1:0] push_data_reg;
  logic [IDX_W-1:0]  push_idx_reg;
  logic              frame_end_reg;
  logic              frame_partial_reg;

  // FIFO state
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_next;
  logic [LVL_W-1:0]  count_reg;
  logic [LVL_W-1:0]  count_next;
  logic [ENT_W-1:0]  head_next;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [IDX_W-1:0]  out_idx_reg;
  logic              overrun_reg;
  logic              pop;
  logic              full;
  logic              wr_en;
  logic              drop;

  assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  assign leading_edge  = (sck_prev_reg == IDLE_SCK) && (sck_s != IDLE_SCK);
  assign trailing_edge = (sck_prev_reg != IDLE_SCK) && (sck_s == IDLE_SCK);
  assign sample_edge   = ((CPHA != 0) ? trailing_edge : leading_edge) &&
                         frame_active_reg && !cs_s;
  assign cs_rise       = frame_active_reg && cs_s;

  // Bring the pins into clk and track whether a frame is open; a frame may only
  // open once cs has been seen high after the synchroniser has refilled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_reg     <= {SYNC_STAGES{IDLE_SCK}};
      cs_sync_reg      <= '1;
      mosi_sync_reg    <= '0;
      settle_reg       <= '0;
      sck_prev_reg     <= IDLE_SCK;
      armed_reg        <= 1'b0;
      frame_active_reg <= 1'b0;
      sample_reg       <= 1'b0;
      mosi_d_reg       <= 1'b0;
      cs_rise_reg      <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      settle_reg    <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
      sck_prev_reg  <= sck_s;
      if (settle_reg[SYNC_STAGES-1] && cs_s) begin
        armed_reg <= 1'b1;
      end
      if (cs_rise) begin
        frame_active_reg <= 1'b0;
      end else if (armed_reg && !cs_s) begin
        frame_active_reg <= 1'b1;
      end
      sample_reg  <= sample_edge;
      mosi_d_reg  <= mosi_s;
      cs_rise_reg <= cs_rise;
    end
  end

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign shift_in = {mosi_d_reg, shift_reg[DATA_W-1:1]};
    end else begin : g_msb_first
      assign shift_in = {shift_reg[DATA_W-2:0], mosi_d_reg};
    end
  endgenerate

  assign word_done = (bit_cnt_reg == CNT_W'(DATA_W));
  assign cnt_base  = word_done ? '0 : bit_cnt_reg;

  // Shift in samples, hand finished words to the FIFO one cycle later, and
  // close frames (a word finishing as cs rises is still delivered).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg         <= '0;
      bit_cnt_reg       <= '0;
      idx_reg           <= '0;
      push_req_reg      <= 1'b0;
      push_data_reg     <= '0;
      push_idx_reg      <= '0;
      frame_end_reg     <= 1'b0;
      frame_partial_reg <= 1'b0;
    end else begin
      push_req_reg <= word_done;
      if (word_done) begin
        push_data_reg <= shift_reg;
        push_idx_reg  <= idx_reg;
      end
      if (sample_reg) begin
        shift_reg   <= shift_in;
        bit_cnt_reg <= cnt_base + CNT_W'(1);
      end else begin
        bit_cnt_reg <= cnt_base;
      end
      if (cs_rise_reg) begin
        bit_cnt_reg <= '0;
        idx_reg     <= '0;
      end else if (word_done && (idx_reg != '1)) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
      frame_end_reg     <= cs_rise_reg;
      frame_partial_reg <= cs_rise_reg && (bit_cnt_reg != '0) && !word_done;
    end
  end

  assign pop        = out_valid_reg && out_ready;
  assign full       = (count_reg == LVL_W'(DEPTH));
  assign wr_en      = push_req_reg && (!full || pop);
  assign drop       = push_req_reg && full && !pop;
  assign rd_next    = rd_ptr_reg + AW'(pop);
  assign count_next = count_reg + LVL_W'(wr_en) - LVL_W'(pop);

  // Next head entry: a word written into an otherwise empty FIFO becomes the head.
  always_comb begin
    head_next = mem[rd_next];
    if (wr_en && (wr_ptr_reg == rd_next)) begin
      head_next = {push_data_reg, push_idx_reg};
    end
  end

  // FIFO storage (no reset needed; the head registers hide stale contents)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= {push_data_reg, push_idx_reg};
    end
  end

  // FIFO pointers, level, registered head and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_idx_reg   <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg    <= rd_next;
      count_reg     <= count_next;
      out_valid_reg <= (count_next != '0);
      if (count_next != '0) begin
        out_data_reg <= head_next[ENT_W-1:IDX_W];
        out_idx_reg  <= head_next[IDX_W-1:0];
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign out_data      = out_data_reg;
  assign out_idx       = out_idx_reg;
  assign out_valid     = out_valid_reg;
  assign frame_end     = frame_end_reg;
  assign frame_partial = frame_partial_reg;
  assign overrun       = overrun_reg;
  assign fifo_level    = count_reg;

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// Bench for spi_slave_rx_fifo: one mode-0 MSB-first instance driven through a
// scoreboard, plus eight instances covering every CPOL/CPHA/bit-order setting.
module tb_spi_slave_rx_fifo;

  localparam int H = 8;  // SCK half period in clk cycles

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
  } exp_t;

  typedef struct {
    int         cfg;
    logic [7:0] tx;
    logic [7:0] exp_data;
  } vec_t;

  logic clk;
  logic reset;
  logic sck_a  [9];
  logic cs_a   [9];
  logic mosi_a [9];

  // main instance signals
  logic [7:0] out_data;
  logic [3:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       ready_base;
  logic       ready_pulse;
  logic       frame_end;
  logic       frame_partial;
  logic       overrun;
  logic       ovr_clr;
  logic [2:0] fifo_level;

  // mode instance signals
  logic [7:0] data_m  [8];
  logic [3:0] idx_m   [8];
  logic       valid_m [8];
  logic       ready_m [8];
  logic       fe_m    [8];
  logic       fp_m    [8];
  logic       ovr_m   [8];
  logic [2:0] lvl_m   [8];

  int   total;
  int   bad;
  int   cyc;
  int   last_edge_cyc;
  int   fe_cnt;
  int   fp_cnt;
  int   fp_alone;
  bit   lat_arm;
  bit   lat_seen;
  bit   pop_arm;
  logic prev_valid;
  exp_t sbq [$];
  vec_t vecs [24];

  assign out_ready = ready_base | ready_pulse;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_rx_fifo #(
    .DATA_W(8), .DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2), .IDX_W(4)
  ) dut (
    .clk(clk), .reset(reset), .sck(sck_a[8]), .cs(cs_a[8]), .mosi(mosi_a[8]),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .frame_end(frame_end), .frame_partial(frame_partial), .overrun(overrun),
    .ovr_clr(ovr_clr), .fifo_level(fifo_level)
  );

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mode
      spi_slave_rx_fifo #(
        .DATA_W(8), .DEPTH(4), .CPOL((gi / 4) % 2), .CPHA((gi / 2) % 2),
        .LSB_FIRST(gi % 2), .SYNC_STAGES(2), .IDX_W(4)
      ) u_mode (
        .clk(clk), .reset(reset), .sck(sck_a[gi]), .cs(cs_a[gi]), .mosi(mosi_a[gi]),
        .out_data(data_m[gi]), .out_idx(idx_m[gi]), .out_valid(valid_m[gi]),
        .out_ready(ready_m[gi]), .frame_end(fe_m[gi]), .frame_partial(fp_m[gi]),
        .overrun(ovr_m[gi]), .ovr_clr(1'b0), .fifo_level(lvl_m[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard, frame-pulse counters and first-word latency measurement
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_data", {24'd0, out_data}, {24'd0, e.data});
          check("sb_idx", {28'd0, out_idx}, {28'd0, e.idx});
          $display("pop data=0x%02h idx=%0d level=%0d", out_data, out_idx, fifo_level);
        end
      end
      if (frame_end) fe_cnt++;
      if (frame_partial) fp_cnt++;
      if (frame_partial && !frame_end) fp_alone++;
      if (lat_arm && out_valid && !prev_valid) begin
        check("latency", cyc - last_edge_cyc, 32'd6);
        lat_arm  = 1'b0;
        lat_seen = 1'b1;
      end
    end
    prev_valid = out_valid;
  end

  // One-cycle ready pulse aligned with the push of the word just finished
  initial begin
    ready_pulse = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      ready_pulse = pop_arm && (cyc == last_edge_cyc + 5);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cs_low(input int c);
    cs_a[c] = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high(input int c);
    wait_clk(H);
    cs_a[c] = 1'b1;
    wait_clk(2 * H);
  endtask

  // Master side: sends the first nbits bits of w in cfg c's mode and bit order
  task automatic spi_word(input int c, input logic [7:0] w, input int nbits);
    logic cpol;
    logic cpha;
    logic lsb;
    logic bitv;
    cpol = ((c >> 2) & 1) != 0;
    cpha = ((c >> 1) & 1) != 0;
    lsb  = (c & 1) != 0;
    for (int b = 0; b < nbits; b++) begin
      bitv = lsb ? w[b] : w[7-b];
      if (!cpha) begin
        mosi_a[c] = bitv;
        wait_clk(H);
        sck_a[c] = ~cpol;
        if (b == nbits - 1) last_edge_cyc = cyc;
        wait_clk(H);
        sck_a[c] = cpol;
      end else begin
        sck_a[c]  = ~cpol;
        mosi_a[c] = bitv;
        wait_clk(H);
        sck_a[c] = cpol;
        if (b == nbits - 1) last_edge_cyc = cyc;
        wait_clk(H);
      end
    end
  endtask

  task automatic expect_word(input logic [7:0] d, input logic [3:0] i);
    exp_t e;
    e.data = d;
    e.idx  = i;
    sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || fifo_level != 3'd0) && n < 300) begin
      wait_clk(1);
      n++;
    end
    if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int fe0;
    int fp0;
    total = 0; bad = 0; cyc = 0; last_edge_cyc = -100;
    fe_cnt = 0; fp_cnt = 0; fp_alone = 0;
    lat_arm = 0; lat_seen = 0; pop_arm = 0; prev_valid = 0;
    for (int c = 0; c < 9; c++) begin
      sck_a[c]  = ((c >> 2) & 1) != 0;
      cs_a[c]   = 1'b1;
      mosi_a[c] = 1'b0;
    end
    for (int c = 0; c < 8; c++) ready_m[c] = 1'b0;
    ready_base = 1'b0;
    ovr_clr = 1'b0;
    reset = 1'b0;

    for (int c = 0; c < 8; c++) begin
      vecs[3*c]   = '{c, 8'h81, 8'h81};
      vecs[3*c+1] = '{c, 8'h01, 8'h01};
      vecs[3*c+2] = '{c, 8'h4B, 8'h4B};
    end

    wait_clk(4);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_idx", {28'd0, out_idx}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_end", {31'd0, frame_end}, 32'd0);
    reset = 1'b1;
    wait_clk(6);

    // Two-word mode-0 frame with latency check on the first word
    ready_base = 1'b1;
    lat_arm = 1'b1;
    fe0 = fe_cnt; fp0 = fp_cnt;
    expect_word(8'hA5, 4'd0);
    expect_word(8'h3C, 4'd1);
    cs_low(8);
    spi_word(8, 8'hA5, 8);
    spi_word(8, 8'h3C, 8);
    cs_high(8);
    wait_drain();
    check("t1_frame_end", fe_cnt - fe0, 32'd1);
    check("t1_partial", fp_cnt - fp0, 32'd0);
    check("t1_latency_seen", {31'd0, lat_seen}, 32'd1);

    // Every mode and bit order, one word per frame
    for (int v = 0; v < 24; v++) begin
      int c;
      c = vecs[v].cfg;
      cs_low(c);
      spi_word(c, vecs[v].tx, 8);
      cs_high(c);
      check($sformatf("mode%0d_valid", c), {31'd0, valid_m[c]}, 32'd1);
      check($sformatf("mode%0d_data", c), {24'd0, data_m[c]}, {24'd0, vecs[v].exp_data});
      check($sformatf("mode%0d_idx", c), {28'd0, idx_m[c]}, 32'd0);
      $display("mode cfg=%0d tx=0x%02h rx=0x%02h", c, vecs[v].tx, data_m[c]);
      ready_m[c] = 1'b1;
      wait_clk(1);
      ready_m[c] = 1'b0;
      wait_clk(1);
      check($sformatf("mode%0d_popped", c), {31'd0, valid_m[c]}, 32'd0);
    end

    // Partial word discarded at frame end
    fe0 = fe_cnt; fp0 = fp_cnt;
    cs_low(8);
    spi_word(8, 8'hFF, 5);
    cs_high(8);
    check("part_frame_end", fe_cnt - fe0, 32'd1);
    check("part_partial", fp_cnt - fp0, 32'd1);
    check("part_level", {29'd0, fifo_level}, 32'd0);
    expect_word(8'h5A, 4'd0);
    cs_low(8);
    spi_word(8, 8'h5A, 8);
    cs_high(8);
    wait_drain();
    check("part_next_clean", fp_cnt - fp0, 32'd1);

    // Overflow: fifth word dropped, overrun sticky until cleared
    ready_base = 1'b0;
    for (int i = 0; i < 4; i++) expect_word(8'h10 + 8'(i), 4'(i));
    cs_low(8);
    for (int i = 0; i < 5; i++) spi_word(8, 8'h10 + 8'(i), 8);
    cs_high(8);
    check("ovf_level", {29'd0, fifo_level}, 32'd4);
    check("ovf_overrun", {31'd0, overrun}, 32'd1);
    ovr_clr = 1'b1;
    wait_clk(1);
    ovr_clr = 1'b0;
    wait_clk(1);
    check("ovf_cleared", {31'd0, overrun}, 32'd0);
    ready_base = 1'b1;
    wait_drain();
    check("ovf_drained", {29'd0, fifo_level}, 32'd0);

    // Full FIFO with a pop on the exact push edge
    ready_base = 1'b0;
    for (int i = 0; i < 5; i++) expect_word(8'h10 + 8'(i), 4'(i));
    cs_low(8);
    for (int i = 0; i < 4; i++) spi_word(8, 8'h10 + 8'(i), 8);
    wait_clk(10);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    pop_arm = 1'b1;
    spi_word(8, 8'h14, 8);
    pop_arm = 1'b0;
    check("full_pop_level", {29'd0, fifo_level}, 32'd4);
    check("full_pop_overrun", {31'd0, overrun}, 32'd0);
    cs_high(8);
    ready_base = 1'b1;
    wait_drain();
    check("full_drained", {29'd0, fifo_level}, 32'd0);

    // Asynchronous reset in the middle of a word
    ready_base = 1'b0;
    cs_low(8);
    spi_word(8, 8'h77, 8);
    wait_clk(10);
    check("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    spi_word(8, 8'hE0, 3);
    #1 reset = 1'b0;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_data", {24'd0, out_data}, 32'd0);
    check("rstmid_level", {29'd0, fifo_level}, 32'd0);
    wait_clk(3);
    reset = 1'b1;
    wait_clk(4);
    cs_high(8);
    ready_base = 1'b1;
    expect_word(8'hC3, 4'd0);
    cs_low(8);
    spi_word(8, 8'hC3, 8);
    cs_high(8);
    wait_drain();

    check("sb_leftover", sbq.size(), 32'd0);
    check("partial_without_end", fp_alone, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
